// File: rtl/two_of_five_pkg.sv
// Shared types and helpers for the two-out-of-five serial receive controller.
package two_of_five_pkg;

  localparam int CODE_W  = 5;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_ABORT,
    ST_OUT
  } state_e;

  // Weight of each codeword bit, indexed by CODE position. The first bit on
  // the line lands in CODE[4] (weight 7) and the last in CODE[0] (weight 0).
  localparam logic [3:0] WEIGHTS [CODE_W] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd7};

  // Weighted sum of a two-hot codeword. 7+4 encodes zero; every other sum
  // is the digit itself. Only meaningful for words the checker accepts.
  function automatic logic [DIGIT_W-1:0] decode_digit(input logic [CODE_W-1:0] code);
    logic [4:0] sum;
    sum = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) sum = sum + {1'b0, WEIGHTS[i]};
    end
    return (sum == 5'd11) ? '0 : sum[DIGIT_W-1:0];
  endfunction

endpackage

// File: rtl/two_of_five_rx_ctrl_if.sv
// Serial-line and digit-handshake signals of the receive controller.
// master = front-end/consumer side, slave = the controller.
interface two_of_five_rx_ctrl_if #(
  parameter int ERR_W = 8
);
  logic             START;
  logic             SDI;
  logic             SDI_VALID;
  logic             DIGIT_READY;
  logic [3:0]       DIGIT;
  logic             DIGIT_VALID;
  logic             ERR;
  logic [ERR_W-1:0] ERR_CNT;
  logic             BUSY;

  modport master (
    output START, SDI, SDI_VALID, DIGIT_READY,
    input  DIGIT, DIGIT_VALID, ERR, ERR_CNT, BUSY
  );

  modport slave (
    input  START, SDI, SDI_VALID, DIGIT_READY,
    output DIGIT, DIGIT_VALID, ERR, ERR_CNT, BUSY
  );
endinterface

// File: rtl/two_of_five_chk.sv
// Two-out-of-five detector: flags any codeword whose popcount is not 2.
module two_of_five_chk
  import two_of_five_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              invalid
);

  logic [2:0] ones;

  // Count set bits and compare against the single legal weight.
  always_comb begin
    ones = '0;
    for (int i = 0; i < CODE_W; i++) begin
      ones = ones + {2'b00, code[i]};
    end
    invalid = (ones != 3'd2);
  end

endmodule

// File: rtl/two_of_five_rx_ctrl.sv
// Serial receiver for two-out-of-five BCD digits: shifts in 5 bits, checks
// and decodes the word, then offers the digit on a valid/ready handshake.
// Bad or timed-out frames produce a one-cycle ERR and bump a saturating count.
module two_of_five_rx_ctrl
  import two_of_five_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ERR_W   = 8
) (
  input logic                CLK,
  input logic                RST,
  two_of_five_rx_ctrl_if.slave bus
);

  localparam int               TO_W    = 8;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e               state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 digit_valid_q, digit_valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic                 code_invalid;

  two_of_five_chk u_chk (
    .code    (code_q),
    .invalid (code_invalid)
  );

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    // NOTE: every _d starts as its _q so no branch leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    code_d      = code_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    digit_d     = digit_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        // An accepted bit takes priority over the timeout in the same cycle.
        if (bus.SDI_VALID) begin
          code_d    = {code_q[CODE_W-2:0], bus.SDI};
          bit_cnt_d = bit_cnt_q + 3'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 3'd4) state_d = ST_CHECK;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_q == TO_LAST) state_d = ST_ABORT;
        end
      end
      ST_CHECK: begin
        if (code_invalid) begin
          state_d = ST_ABORT;
        end else begin
          digit_d = decode_digit(code_q);
          state_d = ST_OUT;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      ST_OUT: begin
        if (bus.DIGIT_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    digit_valid_d = (state_d == ST_OUT);
    err_d         = (state_d == ST_ABORT);
    busy_d        = (state_d != ST_IDLE);
    if (err_d && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (RST) begin
      state_q       <= ST_IDLE;
      code_q        <= '0;
      bit_cnt_q     <= '0;
      to_cnt_q      <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      bit_cnt_q     <= bit_cnt_d;
      to_cnt_q      <= to_cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.DIGIT       = digit_q;
  assign bus.DIGIT_VALID = digit_valid_q;
  assign bus.ERR         = err_q;
  assign bus.ERR_CNT     = err_cnt_q;
  assign bus.BUSY        = busy_q;

endmodule

// File: tb/tb_two_of_five_rx_ctrl.sv
// Bench for two_of_five_rx_ctrl: table of frames plus hand-written corner
// sequences; digit transfers and ERR pulses are matched against a queue.
module tb_two_of_five_rx_ctrl;

  localparam int ERR_W   = 8;
  localparam int ERR_MAX = 255;

  typedef struct {
    logic [4:0] code;       // first bit on the line in [4]
    int         gap;        // idle cycles before bits 2..5
    int         hold;       // cycles DIGIT_READY stays low in OUT
    bit         exp_err;
    logic [3:0] exp_digit;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [3:0] digit;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   exp_err_cnt;
  vec_t vecs[$];
  exp_t sb_q[$];

  two_of_five_rx_ctrl_if #(.ERR_W(ERR_W)) bus ();

  two_of_five_rx_ctrl #(.TIMEOUT(16), .ERR_W(ERR_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ERR pulse or digit transfer pops one expectation.
  always @(negedge clk) begin
    if (!rst && (bus.ERR || (bus.DIGIT_VALID && bus.DIGIT_READY))) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got err=%0b digit=%0d expected no event at %0t",
                 bus.ERR, bus.DIGIT, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_kind_err", 32'(bus.ERR), 32'(e.is_err));
        if (!e.is_err) check("sb_digit", 32'(bus.DIGIT), 32'(e.digit));
      end
    end
  end

  task automatic drive_bits(input logic [4:0] code, input int gap);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (i != 4) begin
        bus.SDI_VALID = 1'b0;
        for (int g = 0; g < gap; g++) step();
      end
      bus.SDI_VALID = 1'b1;
      bus.SDI       = code[i];
      step();
    end
    bus.SDI_VALID = 1'b0;
    bus.SDI       = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    sb_q.push_back('{v.exp_err, v.exp_digit});
    drive_bits(v.code, v.gap);
    // One edge after the 5th bit: still busy, nothing presented yet.
    check("lat_busy", 32'(bus.BUSY), 32'd1);
    check("lat_no_valid", 32'(bus.DIGIT_VALID), 32'd0);
    check("lat_no_err", 32'(bus.ERR), 32'd0);
    step();
    if (v.exp_err) begin
      check("err_pulse", 32'(bus.ERR), 32'd1);
      check("err_no_valid", 32'(bus.DIGIT_VALID), 32'd0);
      if (exp_err_cnt < ERR_MAX) exp_err_cnt++;
      step();
      check("err_single", 32'(bus.ERR), 32'd0);
      check("err_idle", 32'(bus.BUSY), 32'd0);
      check("err_cnt", 32'(bus.ERR_CNT), 32'(exp_err_cnt));
    end else begin
      check("valid_rise", 32'(bus.DIGIT_VALID), 32'd1);
      check("digit", 32'(bus.DIGIT), 32'(v.exp_digit));
      check("valid_no_err", 32'(bus.ERR), 32'd0);
      for (int h = 0; h < v.hold; h++) begin
        bus.START = (h == 1);
        step();
        check("hold_valid", 32'(bus.DIGIT_VALID), 32'd1);
        check("hold_digit", 32'(bus.DIGIT), 32'(v.exp_digit));
      end
      bus.START       = 1'b0;
      bus.DIGIT_READY = 1'b1;
      step();
      bus.DIGIT_READY = 1'b0;
      check("xfer_valid_low", 32'(bus.DIGIT_VALID), 32'd0);
      check("xfer_idle", 32'(bus.BUSY), 32'd0);
      check("xfer_err_cnt", 32'(bus.ERR_CNT), 32'(exp_err_cnt));
    end
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    exp_err_cnt     = 0;
    rst             = 1'b1;
    bus.START       = 1'b0;
    bus.SDI         = 1'b0;
    bus.SDI_VALID   = 1'b0;
    bus.DIGIT_READY = 1'b0;

    vecs.push_back('{5'b01010, 0, 0, 1'b0, 4'd5});
    vecs.push_back('{5'b11000, 0, 0, 1'b0, 4'd0});
    vecs.push_back('{5'b10100, 3, 0, 1'b0, 4'd9});
    vecs.push_back('{5'b11100, 0, 0, 1'b1, 4'd0});
    vecs.push_back('{5'b00000, 0, 0, 1'b1, 4'd0});
    vecs.push_back('{5'b00110, 0, 0, 1'b0, 4'd3});
    vecs.push_back('{5'b10010, 1, 0, 1'b0, 4'd8});
    vecs.push_back('{5'b01001, 0, 0, 1'b0, 4'd4});
    vecs.push_back('{5'b00011, 2, 0, 1'b0, 4'd1});
    vecs.push_back('{5'b00101, 0, 0, 1'b0, 4'd2});
    vecs.push_back('{5'b01100, 15, 0, 1'b0, 4'd6});
    vecs.push_back('{5'b10001, 0, 4, 1'b0, 4'd7});
    vecs.push_back('{5'b11111, 1, 0, 1'b1, 4'd0});

    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_valid", 32'(bus.DIGIT_VALID), 32'd0);
    check("rst_err", 32'(bus.ERR), 32'd0);
    check("rst_err_cnt", 32'(bus.ERR_CNT), 32'd0);
    check("rst_digit", 32'(bus.DIGIT), 32'd0);

    // Serial bits and READY while idle must not wake the controller.
    bus.SDI_VALID   = 1'b1;
    bus.SDI         = 1'b1;
    bus.DIGIT_READY = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_ignore_sdi", 32'(bus.BUSY), 32'd0);
    bus.SDI_VALID   = 1'b0;
    bus.SDI         = 1'b0;
    bus.DIGIT_READY = 1'b0;

    foreach (vecs[i]) send_frame(vecs[i]);

    // Timeout: 3 bits, then 16 cycles without SDI_VALID aborts the frame.
    sb_q.push_back('{1'b1, 4'd0});
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.SDI_VALID = 1'b1;
      bus.SDI       = i[0];
      step();
    end
    bus.SDI_VALID = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("to_busy_before", 32'(bus.BUSY), 32'd1);
    check("to_no_err_before", 32'(bus.ERR), 32'd0);
    step();
    check("to_err_pulse", 32'(bus.ERR), 32'd1);
    if (exp_err_cnt < ERR_MAX) exp_err_cnt++;
    step();
    check("to_err_single", 32'(bus.ERR), 32'd0);
    check("to_idle", 32'(bus.BUSY), 32'd0);
    check("to_err_cnt", 32'(bus.ERR_CNT), 32'(exp_err_cnt));

    // Saturate the error counter.
    for (int i = 0; i < 260; i++) send_frame('{5'b00000, 0, 0, 1'b1, 4'd0});
    check("err_cnt_saturated", 32'(bus.ERR_CNT), 32'd255);

    // Reset mid-SHIFT clears everything, including the saturated count.
    bus.START = 1'b1;
    step();
    bus.START     = 1'b0;
    bus.SDI_VALID = 1'b1;
    bus.SDI       = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_shift_busy", 32'(bus.BUSY), 32'd0);
    check("rst_shift_valid", 32'(bus.DIGIT_VALID), 32'd0);
    check("rst_shift_err", 32'(bus.ERR), 32'd0);
    check("rst_shift_err_cnt", 32'(bus.ERR_CNT), 32'd0);
    check("rst_shift_digit", 32'(bus.DIGIT), 32'd0);
    exp_err_cnt = 0;
    step();
    step();
    bus.SDI_VALID = 1'b0;
    check("rst_shift_no_err", 32'(bus.ERR), 32'd0);
    check("rst_shift_stay_idle", 32'(bus.BUSY), 32'd0);

    // Reset while a digit is pending drops it without a transfer.
    drive_bits(5'b10001, 0);
    step();
    check("pend_valid", 32'(bus.DIGIT_VALID), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("pend_rst_valid", 32'(bus.DIGIT_VALID), 32'd0);
    check("pend_rst_busy", 32'(bus.BUSY), 32'd0);
    check("pend_rst_digit", 32'(bus.DIGIT), 32'd0);

    // Recovery frame after reset.
    send_frame('{5'b01010, 0, 0, 1'b0, 4'd5});
    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
